// File: rtl/ht_mport_frontend_if.sv
// Client-side command/result bus of the hash-table multi-port front end.
// The master modport is the client side; the slave modport is the front end.
interface ht_mport_frontend_if #(
    parameter int CHANNELS = 4,
    parameter int CMD_W    = 64,
    parameter int RES_W    = 96
);
    logic [CHANNELS*CMD_W-1:0] cmd;
    logic [CHANNELS-1:0]       cmd_valid;
    logic [CHANNELS-1:0]       cmd_ready;
    logic [RES_W-1:0]          res;
    logic [CHANNELS-1:0]       res_valid;
    logic [CHANNELS-1:0]       res_ready;

    modport master (
        output cmd, cmd_valid, res_ready,
        input  cmd_ready, res, res_valid
    );

    modport slave (
        input  cmd, cmd_valid, res_ready,
        output cmd_ready, res, res_valid
    );
endinterface

// File: rtl/ht_mport_frontend.sv
// Multi-channel front end: round-robin command arbitration, in-order result
// steering through a channel-tag FIFO, and the RAM clear sequencer.
module ht_mport_frontend #(
    parameter int CHANNELS  = 4,
    parameter int CMD_W     = 64,
    parameter int RES_W     = 96,
    parameter int TAG_DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ht_mport_frontend_if.slave   cli,
    output logic [CMD_W-1:0]     pl_cmd_o,
    output logic                 pl_cmd_valid_o,
    input  logic                 pl_cmd_ready_i,
    input  logic [RES_W-1:0]     pl_res_i,
    input  logic                 pl_res_valid_i,
    output logic                 pl_res_ready_o,
    input  logic                 clear_req_i,
    output logic                 clear_run_o,
    input  logic                 clear_done_i,
    output logic                 busy_o,
    output logic                 orphan_err_o
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int AW   = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {
        CLR_START = 2'd0,
        CLR_WAIT  = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic              clear_run_q, clear_run_d;
    logic              orphan_q, orphan_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CH_W-1:0]   tag_mem_q [TAG_DEPTH];

    logic [CH_W:0]     cand_s;
    logic              search_hit_s;
    logic              search_found_s;
    logic [CH_W-1:0]   search_ch_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              grant_valid_s;
    logic [CH_W-1:0]   grant_ch_s;
    logic              handshake_s;
    logic [CMD_W-1:0]  pl_cmd_s;
    logic [CHANNELS-1:0] cmd_ready_s;
    logic [CH_W-1:0]   head_tag_s;
    logic [CHANNELS-1:0] res_valid_s;
    logic              pl_res_ready_s;
    logic              pop_s;

    assign fifo_full_s  = (count_q == (AW+1)'(TAG_DEPTH));
    assign fifo_empty_s = (count_q == (AW+1)'(0));
    assign head_tag_s   = tag_mem_q[rd_ptr_q];

    // Round-robin search: first valid channel at or after rr_ptr_q, wrapping.
    always_comb begin
        cand_s         = '0;
        search_hit_s   = 1'b0;
        search_found_s = 1'b0;
        search_ch_s    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            cand_s = (cand_s >= (CH_W+1)'(CHANNELS)) ? cand_s - (CH_W+1)'(CHANNELS) : cand_s;
            search_hit_s   = !search_found_s && cli.cmd_valid[cand_s[CH_W-1:0]];
            search_ch_s    = search_hit_s ? cand_s[CH_W-1:0] : search_ch_s;
            search_found_s = search_found_s | search_hit_s;
        end
    end

    // A locked grant persists across DRAIN and a full FIFO until its handshake.
    always_comb begin
        grant_valid_s = lock_q | ((state_q == RUN) & ~fifo_full_s & search_found_s);
        grant_ch_s    = lock_q ? lock_ch_q : search_ch_s;
        handshake_s   = grant_valid_s & pl_cmd_ready_i;
        pl_cmd_s      = '0;
        cmd_ready_s   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pl_cmd_s       = pl_cmd_s | ({CMD_W{grant_ch_s == CH_W'(k)}} & cli.cmd[k*CMD_W +: CMD_W]);
            cmd_ready_s[k] = handshake_s & (grant_ch_s == CH_W'(k));
        end
    end

    // Results follow issue order, so the FIFO head names the owning channel.
    always_comb begin
        res_valid_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            res_valid_s[k] = pl_res_valid_i & ~fifo_empty_s & (head_tag_s == CH_W'(k));
        end
        pl_res_ready_s = fifo_empty_s ? pl_res_valid_i : cli.res_ready[head_tag_s];
        pop_s          = pl_res_valid_i & ~fifo_empty_s & cli.res_ready[head_tag_s];
    end

    // Next-state for the clear sequencer, arbiter state and tag FIFO pointers.
    always_comb begin
        state_d     = state_q;
        clear_run_d = (state_q == CLR_START);
        case (state_q)
            CLR_START: state_d = CLR_WAIT;
            // The pulse cycle itself is skipped: done may still be high from the previous clear.
            CLR_WAIT:  state_d = (!clear_run_q && clear_done_i) ? RUN : CLR_WAIT;
            RUN:       state_d = clear_req_i ? DRAIN : RUN;
            DRAIN:     state_d = (fifo_empty_s && !lock_q) ? CLR_START : DRAIN;
            default:   state_d = CLR_START;
        endcase

        lock_d    = grant_valid_s & ~pl_cmd_ready_i;
        lock_ch_d = grant_valid_s ? grant_ch_s : lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (handshake_s) begin
            rr_ptr_d = (grant_ch_s == CH_W'(CHANNELS - 1)) ? '0 : grant_ch_s + CH_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        wr_ptr_d = handshake_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({handshake_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        orphan_d = orphan_q | (pl_res_valid_i & fifo_empty_s);
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CLR_START;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            clear_run_q <= 1'b0;
            orphan_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            clear_run_q <= clear_run_d;
            orphan_q    <= orphan_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Tag storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (handshake_s) begin
            tag_mem_q[wr_ptr_q] <= grant_ch_s;
        end
    end

    assign pl_cmd_o       = pl_cmd_s;
    assign pl_cmd_valid_o = grant_valid_s;
    assign cli.cmd_ready  = cmd_ready_s;
    assign cli.res        = pl_res_i;
    assign cli.res_valid  = res_valid_s;
    assign pl_res_ready_o = pl_res_ready_s;
    assign clear_run_o    = clear_run_q;
    assign busy_o         = (state_q != RUN);
    assign orphan_err_o   = orphan_q;
endmodule

// File: tb/tb_ht_mport_frontend.sv
// Directed self-checking bench for ht_mport_frontend with 4 channels.
module tb_ht_mport_frontend;
    localparam int CH = 4;
    localparam int CW = 64;
    localparam int RW = 96;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] pl_cmd;
    logic          pl_cmd_valid;
    logic          pl_cmd_ready;
    logic [RW-1:0] pl_res;
    logic          pl_res_valid;
    logic          pl_res_ready;
    logic          clear_req;
    logic          clear_run;
    logic          clear_done;
    logic          busy;
    logic          orphan;
    int            tests  = 0;
    int            failed = 0;

    always #5 clk = ~clk;

    ht_mport_frontend_if #(.CHANNELS(CH), .CMD_W(CW), .RES_W(RW)) bus ();

    ht_mport_frontend #(.CHANNELS(CH), .CMD_W(CW), .RES_W(RW), .TAG_DEPTH(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cli            (bus.slave),
        .pl_cmd_o       (pl_cmd),
        .pl_cmd_valid_o (pl_cmd_valid),
        .pl_cmd_ready_i (pl_cmd_ready),
        .pl_res_i       (pl_res),
        .pl_res_valid_i (pl_res_valid),
        .pl_res_ready_o (pl_res_ready),
        .clear_req_i    (clear_req),
        .clear_run_o    (clear_run),
        .clear_done_i   (clear_done),
        .busy_o         (busy),
        .orphan_err_o   (orphan)
    );

    function automatic logic [CW-1:0] cmd_word(input int k);
        return {32'hC0DE_0000, 32'(k)};
    endfunction

    function automatic logic [CH-1:0] oh(input int k);
        logic [CH-1:0] one;
        one = 4'b0001;
        return one << k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.cmd_valid = 4'b0000;
        bus.res_ready = 4'b0000;
        pl_cmd_ready  = 1'b0;
        pl_res        = 96'h0;
        pl_res_valid  = 1'b0;
        clear_req     = 1'b0;
        clear_done    = 1'b0;
        for (int k = 0; k < CH; k++) bus.cmd[k*CW +: CW] = cmd_word(k);
        tick();
        tick();
        chk("rst_busy",      128'(busy),          128'(1'b1));
        chk("rst_clear_run", 128'(clear_run),     128'(1'b0));
        chk("rst_pl_valid",  128'(pl_cmd_valid),  128'(1'b0));
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(4'b0000));
        chk("rst_res_ready", 128'(pl_res_ready),  128'(1'b0));
        chk("rst_orphan",    128'(orphan),        128'(1'b0));

        // Reset release with tables already reporting done: done must be ignored during the pulse.
        rst           = 1'b0;
        clear_done    = 1'b1;
        bus.cmd_valid = 4'b1111;
        pl_cmd_ready  = 1'b1;
        tick();
        chk("clr_pulse_on",   128'(clear_run),     128'(1'b1));
        chk("clr_busy_a",     128'(busy),          128'(1'b1));
        chk("clr_no_ready_a", 128'(bus.cmd_ready), 128'(4'b0000));
        tick();
        chk("clr_pulse_off",  128'(clear_run),     128'(1'b0));
        chk("clr_busy_b",     128'(busy),          128'(1'b1));
        chk("clr_no_ready_b", 128'(bus.cmd_ready), 128'(4'b0000));
        tick();
        chk("run_busy_low",   128'(busy),          128'(1'b0));

        // All channels valid: grants rotate 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", 128'(bus.cmd_ready), 128'(oh(i % 4)));
            chk("rr_cmd",   128'(pl_cmd),        128'(cmd_word(i % 4)));
            tick();
        end
        bus.cmd_valid = 4'b0000;
        bus.res_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            pl_res       = {32'hFEED_0000 | 32'(i), 64'h0123_4567_89AB_CDEF};
            pl_res_valid = 1'b1;
            #1;
            chk("res_steer",  128'(bus.res_valid), 128'(oh(i % 4)));
            chk("res_ready",  128'(pl_res_ready),  128'(1'b1));
            chk("res_data",   128'(bus.res),       128'({32'hFEED_0000 | 32'(i), 64'h0123_4567_89AB_CDEF}));
            tick();
        end
        pl_res_valid = 1'b0;

        // rr_ptr is 2: channel 2 held under backpressure while channel 0 also waits.
        bus.cmd_valid = 4'b0101;
        pl_cmd_ready  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lock_valid", 128'(pl_cmd_valid),  128'(1'b1));
            chk("lock_cmd",   128'(pl_cmd),        128'(cmd_word(2)));
            chk("lock_ready", 128'(bus.cmd_ready), 128'(4'b0000));
            tick();
        end
        pl_cmd_ready = 1'b1;
        #1;
        chk("lock_release", 128'(bus.cmd_ready), 128'(4'b0100));
        tick();
        chk("after_lock_grant", 128'(bus.cmd_ready), 128'(4'b0001));
        tick();

        // Fill the tag FIFO: 2 outstanding plus 14 more grants starting at channel 1.
        bus.cmd_valid = 4'b1111;
        #1;
        for (int i = 0; i < 14; i++) begin
            chk("fill_grant", 128'(bus.cmd_ready), 128'(oh((i + 1) % 4)));
            tick();
        end
        chk("full_no_valid", 128'(pl_cmd_valid),  128'(1'b0));
        chk("full_no_ready", 128'(bus.cmd_ready), 128'(4'b0000));
        pl_res_valid = 1'b1;
        pl_res       = 96'h5A5A;
        #1;
        chk("full_head_tag",     128'(bus.res_valid), 128'(4'b0100));
        chk("full_same_cycle",   128'(pl_cmd_valid),  128'(1'b0));
        tick();
        pl_res_valid = 1'b0;
        #1;
        chk("slot_freed_grant", 128'(bus.cmd_ready), 128'(4'b1000));
        tick();
        bus.cmd_valid = 4'b0000;
        pl_res_valid  = 1'b1;
        #1;
        chk("pop_tag0", 128'(bus.res_valid), 128'(4'b0001));
        tick();

        // Channel 1 stalls its result for two cycles.
        bus.res_ready = 4'b1101;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("bp_pl_ready", 128'(pl_res_ready),  128'(1'b0));
            chk("bp_valid",    128'(bus.res_valid), 128'(4'b0010));
            tick();
        end
        bus.res_ready = 4'b1111;
        #1;
        chk("bp_release", 128'(pl_res_ready), 128'(1'b1));
        tick();
        for (int i = 0; i < 9; i++) begin
            chk("drain_order", 128'(bus.res_valid), 128'(oh((i + 2) % 4)));
            tick();
        end

        // Runtime clear with 5 results outstanding.
        pl_res_valid = 1'b0;
        clear_req    = 1'b1;
        tick();
        clear_req     = 1'b0;
        clear_done    = 1'b0;
        bus.cmd_valid = 4'b1111;
        #1;
        chk("drain_busy",     128'(busy),          128'(1'b1));
        chk("drain_no_grant", 128'(pl_cmd_valid),  128'(1'b0));
        chk("drain_no_ready", 128'(bus.cmd_ready), 128'(4'b0000));
        pl_res_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_res",    128'(bus.res_valid), 128'(oh((i + 3) % 4)));
            chk("drain_no_clr", 128'(clear_run),     128'(1'b0));
            tick();
        end
        pl_res_valid = 1'b0;
        n = 0;
        while (clear_run !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("reclear_pulse", 128'(clear_run),     128'(1'b1));
        chk("reclear_ready", 128'(bus.cmd_ready), 128'(4'b0000));
        clear_done = 1'b1;
        tick();
        chk("reclear_pulse_off", 128'(clear_run), 128'(1'b0));
        chk("reclear_busy",      128'(busy),      128'(1'b1));
        tick();
        chk("rerun_busy",  128'(busy),          128'(1'b0));
        chk("rerun_grant", 128'(bus.cmd_ready), 128'(4'b0001));
        bus.cmd_valid = 4'b0000;

        // Orphan result with the FIFO empty.
        pl_res_valid = 1'b1;
        #1;
        chk("orphan_ready",  128'(pl_res_ready),  128'(1'b1));
        chk("orphan_nores",  128'(bus.res_valid), 128'(4'b0000));
        chk("orphan_before", 128'(orphan),        128'(1'b0));
        tick();
        pl_res_valid = 1'b0;
        #1;
        chk("orphan_set", 128'(orphan), 128'(1'b1));
        tick();
        tick();
        chk("orphan_sticky", 128'(orphan), 128'(1'b1));

        rst = 1'b1;
        #1;
        chk("rst2_orphan", 128'(orphan),    128'(1'b0));
        chk("rst2_busy",   128'(busy),      128'(1'b1));
        chk("rst2_clr",    128'(clear_run), 128'(1'b0));
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
